fx_accum_dump: RTL
==================

Name: fx_accum_dump

Overview:
Fixed-point accumulate-and-dump stage that sits directly downstream of the fixed-point adder. It consumes the adder's registered, format-matched result (signed two's complement) and sums ACC_LEN valid samples. It then emits one rounded, format-matched block average (or block sum) and restarts. It provides the integrate/decimate step for adder-tree datapaths.

Parameters:
IN_W, 12, input sample width (signed), equal to the adder's output width
ACC_LEN, 8, samples per dump; must be ≥2
SHIFT, 3, arithmetic right shift applied to the sum (3 with ACC_LEN=8 gives the mean; 0 gives the raw sum)
OUT_W, 12, output width (signed)
ACC_W, IN_W+$clog2(ACC_LEN), derived accumulator width; not overridable

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_valid  input  1  i_data qualifier; one sample per cycle when high
i_data  input  IN_W  signed sample from the upstream adder
i_clear  input  1  synchronous abort of the current block
o_valid  output  1  single-cycle pulse; o_data is a new result
o_data  output  OUT_W  signed dump result; held between dumps
o_cnt  output  $clog2(ACC_LEN)  samples accumulated in the current block
o_ovf  output  1  saturation flag; meaningful only with the optional feature

Behaviour:
- Clocking and reset: one clock (i_clk). Reset i_rst is asynchronous, active-high. On i_rst: acc=0, cnt=0, o_data=0, o_valid=0, o_ovf=0. Reset mid-block discards the partial sum.
- Sign handling: i_data is sign-extended to ACC_W. Accumulation never overflows inside ACC_W.
- Sample acceptance:
  - Sample with cnt==0: acc <= ext(i_data).
  - Sample with 0<cnt<ACC_LEN-1: acc <= acc + ext(i_data); cnt++.
  - Sample with cnt==ACC_LEN-1 (last sample): sum = acc + ext(i_data); the dump path loads o_data; o_valid=1 on the next cycle; cnt <= 0.
- Latency: o_valid rises exactly 1 cycle after the last sample of a block. There is no backpressure; o_valid is never asserted for two consecutive cycles unless ACC_LEN samples arrive in between (impossible for ACC_LEN≥2).
- Bubbles: i_valid=0 holds acc and cnt. Bubbles do not count toward ACC_LEN.
- Dump arithmetic:
  - If SHIFT>0: r = (sum + 2^(SHIFT-1)) >>> SHIFT, computed at ACC_W+1 bits (round half up, toward +inf).
  - If SHIFT=0: r = sum.
  - r is then narrowed to OUT_W (see Optional Feature).
- i_clear: cnt <= 0 and the partial sum is discarded; no o_valid. i_clear has priority over i_valid in the same cycle, so that sample is dropped, including a would-be last sample.
- o_data: updates only on a dump; otherwise it holds its value.
- o_ovf: updates with o_data and holds its value until the next dump.

Optional Feature:
Macro FX_ACC_SAT_EN.
- Defined: r is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. o_ovf=1 on the dump whose r was clipped, else 0.
- Undefined: o_data = low OUT_W bits of r (wrap-around), and o_ovf is tied to 0.

Decomposition:
- Shared package fx_pkg:
  - rounding-mode and overflow-mode enum constants (RND_HALF_UP, OVF_SAT, OVF_WRAP)
  - a clog2 helper constant function
  - sat_max/sat_min functions of width
- One natural sub-module: fx_round_sat. It is combinational and contains the rounding shift plus the narrow/saturate logic, parameterised by input width, SHIFT and OUT_W. It is reusable by other format-matching stages.
- Counter, accumulator and dump control stay in fx_accum_dump.

Test Plan:
All scenarios use defaults (IN_W=12, ACC_LEN=8, SHIFT=3, OUT_W=12) unless stated.
- Block of constants: 8 consecutive samples of +100 -> o_valid pulses once, 1 cycle after the 8th sample, with o_data=100; o_cnt returns to 0.
- Rounding at the boundary: block with sum=+4 (first sample 4, rest 0) -> o_data=1. Block with sum=+3 -> o_data=0. Block with sum=-4 -> o_data=0. Block with sum=-5 -> o_data=-1.
- Overflow (SHIFT=0 build): 8 samples of +2047 (sum 16376):
  - FX_ACC_SAT_EN defined -> o_data=2047, o_ovf=1.
  - FX_ACC_SAT_EN undefined -> o_data=-8, o_ovf=0.
- Bubbles and clear:
  - 8 samples of 10 interleaved with random i_valid=0 gaps -> a single dump with o_data=10.
  - 5 samples of 50, then i_clear together with an i_valid sample of 999, then 8 samples of -20 -> exactly one o_valid, with o_data=-20.
- Async reset mid-block: i_rst asserted between clock edges after 3 samples -> o_valid=0, o_data=0, o_cnt=0 immediately. After release, 8 samples of 7 -> o_data=7.

Source files
------------

// File: rtl/fx_pkg.sv
// Shared fixed-point helpers: rounding/overflow mode constants, clog2 and
// saturation bounds used by format-matching stages.
package fx_pkg;

  typedef enum logic {
    RND_HALF_UP = 1'b0
  } rnd_mode_e;

  typedef enum logic {
    OVF_SAT  = 1'b0,
    OVF_WRAP = 1'b1
  } ovf_mode_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Bounds of a w-bit signed value, widened to 64 bits for comparison.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Combinational rounding right-shift plus narrowing to OUT_W bits.
// Define FX_ACC_SAT_EN to saturate (and flag clipping) instead of wrapping.
module fx_round_sat
  import fx_pkg::*;
#(
  parameter int        IN_W     = 15,
  parameter int        SHIFT    = 3,
  parameter int        OUT_W    = 12,
  parameter rnd_mode_e RND_MODE = RND_HALF_UP
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  localparam int W1 = IN_W + 1;

`ifdef FX_ACC_SAT_EN
  localparam ovf_mode_e OVF_MODE = OVF_SAT;
`else
  localparam ovf_mode_e OVF_MODE = OVF_WRAP;
`endif

  logic signed [W1-1:0] ext;
  logic signed [W1-1:0] r;
  logic signed [63:0]   r64;

  // One guard bit so adding the rounding constant can never overflow.
  assign ext = {din[IN_W-1], din};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic [W1-1:0] HALF =
        (RND_MODE == RND_HALF_UP) ? (W1'(1) << (SHIFT - 1)) : '0;
      logic signed [W1-1:0] biased;
      assign biased = ext + $signed(HALF);
      assign r      = biased >>> SHIFT;
    end else begin : g_pass
      assign r = ext;
    end
  endgenerate

  assign r64 = {{(64 - W1){r[W1-1]}}, r};

  generate
    if (OVF_MODE == OVF_SAT) begin : g_sat
      always_comb begin
        dout = r64[OUT_W-1:0];
        ovf  = 1'b0;
        if (r64 > sat_max(OUT_W)) begin
          dout = OUT_W'(sat_max(OUT_W));
          ovf  = 1'b1;
        end else if (r64 < sat_min(OUT_W)) begin
          dout = OUT_W'(sat_min(OUT_W));
          ovf  = 1'b1;
        end
      end
    end else begin : g_wrap
      logic unused_hi;
      assign unused_hi = ^r64[63:OUT_W];
      assign dout      = r64[OUT_W-1:0];
      assign ovf       = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/fx_accum_dump.sv
// Accumulate ACC_LEN signed samples, then dump one rounded/narrowed result.
// Saturation of the dump is enabled by defining FX_ACC_SAT_EN.
module fx_accum_dump
  import fx_pkg::*;
#(
  parameter int IN_W    = 12,
  parameter int ACC_LEN = 8,
  parameter int SHIFT   = 3,
  parameter int OUT_W   = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic signed [IN_W-1:0]    i_data,
  input  logic                      i_clear,
  output logic                      o_valid,
  output logic signed [OUT_W-1:0]   o_data,
  output logic [clog2(ACC_LEN)-1:0] o_cnt,
  output logic                      o_ovf
);

  localparam int CNT_W = clog2(ACC_LEN);
  localparam int ACC_W = IN_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        cnt;
  logic signed [OUT_W-1:0] rs_data;
  logic                    rs_ovf;

  assign ext = {{(ACC_W - IN_W){i_data[IN_W-1]}}, i_data};
  // The first sample of a block replaces whatever acc holds.
  assign base = (cnt == '0) ? '0 : acc;
  assign sum  = base + ext;

  fx_round_sat #(
    .IN_W (ACC_W),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W)
  ) u_round_sat (
    .din (sum),
    .dout(rs_data),
    .ovf (rs_ovf)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc     <= '0;
      cnt     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (i_valid) begin
        if (cnt == LAST) begin
          acc     <= '0;
          cnt     <= '0;
          o_data  <= rs_data;
          o_ovf   <= rs_ovf;
          o_valid <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign o_cnt = cnt;

endmodule
